// File: rtl/riscv_xcrypto_issue.sv
// XCrypto (custom-0x2B) issue/response unit: forwards a decoded op to an external coprocessor
// over req/gnt/rvalid, stalls the core while the op is in flight and presents the result.
module riscv_xcrypto_issue #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid_i,
  input  logic [31:0] instr_i,
  input  logic [31:0] rs1_data_i,
  input  logic [31:0] rs2_data_i,
  input  logic        flush_i,
  input  logic        wb_ready_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        illegal_insn_o,
  output logic        cop_err_o,
  output logic        result_valid_o,
  output logic [31:0] result_o,
  output logic [4:0]  result_rd_o,
  output logic        cop_req_o,
  input  logic        cop_gnt_i,
  output logic [9:0]  cop_funct_o,
  output logic [31:0] cop_op_a_o,
  output logic [31:0] cop_op_b_o,
  input  logic        cop_rvalid_i,
  input  logic [31:0] cop_rdata_i,
  input  logic        cop_err_i
);

  localparam logic [6:0] OpcXcrypto  = 7'h2B;
  localparam logic [2:0] Funct3Rsvd  = 3'b111;
  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      r_state;
  logic        r_discard;
  logic [7:0]  r_cnt;
  logic        r_busy;
  logic        r_cop_req;
  logic        r_result_valid;
  logic        r_illegal;
  logic        r_cop_err;
  logic [31:0] r_result;
  logic [4:0]  r_rd;
  logic [9:0]  r_funct;
  logic [31:0] r_op_a;
  logic [31:0] r_op_b;

  logic w_accept;
  logic w_kill;
  logic w_unused;

  assign w_accept = id_valid_i && (instr_i[6:0] == OpcXcrypto) && (r_state == StIdle) && !flush_i;
  // A flush arriving in the same cycle as the response already kills it.
  assign w_kill   = r_discard | flush_i;
  // Register-index fields are resolved upstream; operands arrive already forwarded.
  assign w_unused = ^instr_i[24:15];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= StIdle;
      r_discard      <= 1'b0;
      r_cnt          <= 8'd0;
      r_busy         <= 1'b0;
      r_cop_req      <= 1'b0;
      r_result_valid <= 1'b0;
      r_illegal      <= 1'b0;
      r_cop_err      <= 1'b0;
      r_result       <= 32'd0;
      r_rd           <= 5'd0;
      r_funct        <= 10'd0;
      r_op_a         <= 32'd0;
      r_op_b         <= 32'd0;
    end else begin
      r_illegal <= 1'b0;
      r_cop_err <= 1'b0;
      unique case (r_state)
        StIdle: begin
          r_discard <= 1'b0;
          if (w_accept) begin
            if (instr_i[14:12] == Funct3Rsvd) begin
              r_illegal <= 1'b1;
            end else begin
              r_funct   <= {instr_i[31:25], instr_i[14:12]};
              r_op_a    <= rs1_data_i;
              r_op_b    <= rs2_data_i;
              r_rd      <= instr_i[11:7];
              r_state   <= StReq;
              r_cop_req <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end
        StReq: begin
          // Request stays up through a flush; only the outcome is discarded.
          if (flush_i) begin
            r_discard <= 1'b1;
          end
          if (cop_gnt_i) begin
            r_state   <= StWait;
            r_cop_req <= 1'b0;
            r_cnt     <= 8'd0;
          end
        end
        StWait: begin
          if (cop_rvalid_i) begin
            if (w_kill) begin
              r_state   <= StIdle;
              r_busy    <= 1'b0;
              r_discard <= 1'b0;
            end else if (cop_err_i) begin
              r_cop_err <= 1'b1;
              r_state   <= StIdle;
              r_busy    <= 1'b0;
            end else begin
              r_result       <= cop_rdata_i;
              r_result_valid <= 1'b1;
              r_state        <= StResp;
            end
          end else if (r_cnt == TimeoutLast) begin
            r_cop_err <= !w_kill;
            r_state   <= StIdle;
            r_busy    <= 1'b0;
            r_discard <= 1'b0;
          end else begin
            r_cnt     <= r_cnt + 8'd1;
            r_discard <= w_kill;
          end
        end
        StResp: begin
          if (flush_i || wb_ready_i) begin
            r_result_valid <= 1'b0;
            r_state        <= StIdle;
            r_busy         <= 1'b0;
          end
        end
        default: begin
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign stall_o        = r_busy | w_accept;
  assign busy_o         = r_busy;
  assign illegal_insn_o = r_illegal;
  assign cop_err_o      = r_cop_err;
  assign result_valid_o = r_result_valid;
  assign result_o       = r_result;
  assign result_rd_o    = r_rd;
  assign cop_req_o      = r_cop_req;
  assign cop_funct_o    = r_funct;
  assign cop_op_a_o     = r_op_a;
  assign cop_op_b_o     = r_op_b;

endmodule
